wr_mux: RTL and testbench
=========================

# wr_mux

Master-to-slave half of the AHB interconnect, mirroring the read-side response multiplexer. Routes address/control from the granted master (HMASTER) and write data from the data-phase master to the shared slave bus. Decodes HADDR into a one-hot slave select, and registers the data-phase select and master so read data and responses can be steered back. Optionally contains an internal default slave that returns a two-cycle ERROR response for unmapped accesses.

## Interface
- NUM_SLV, 5: number of decoded slaves; select width.
- DEC_LSB, 28: HADDR[DEC_LSB+3:DEC_LSB] is the region index; region k < NUM_SLV selects slave k.
- CLK  in  1  bus clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- HMASTER  in  4  granted master, address phase; legal values 0..4.
- HREADY  in  1  global transfer-done, from the read-side mux.
- HADDR0..HADDR4  in  32 each  master address.
- HTRANS0..HTRANS4  in  2 each  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HWRITE0..HWRITE4  in  1 each  master write flag.
- HSIZE0..HSIZE4  in  3 each  master transfer size.
- HWDATA0..HWDATA4  in  32 each  master write data.
- sHADDR, sHTRANS, sHWRITE, sHSIZE  out  32/2/1/3  muxed address/control to slaves.
- sHWDATA  out  32  muxed write data to slaves.
- HSEL  out  NUM_SLV  one-hot address-phase slave select.
- HSEL_dp  out  NUM_SLV  registered data-phase select, feeds the read-side mux.
- HMASTER_dp  out  4  registered data-phase master.
- dsHREADY, dsHRESP  out  1/2  default-slave ready/response.

## Operation
- Address mux, combinational: sHADDR/sHTRANS/sHWRITE/sHSIZE = master[HMASTER] signals. HMASTER > 4 drives sHADDR=0, sHTRANS=IDLE, sHWRITE=0, sHSIZE=0.
- Decode, combinational: if region < NUM_SLV, HSEL = 1<<region; otherwise HSEL = 0. Decode is independent of HTRANS.
- Data-phase pipeline: on each CLK edge with HREADY=1, HMASTER_dp <= HMASTER and HSEL_dp <= HSEL. With HREADY=0, both hold.
- Write data: sHWDATA = HWDATA[HMASTER_dp]. HMASTER_dp > 4 drives 0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: dsHREADY=1, dsHRESP=OKAY(00). On HREADY=1 with HSEL==0 and sHTRANS in {NONSEQ, SEQ}, go to ERR1.
  - ERR1: dsHREADY=0, dsHRESP=ERROR(01). Always go to ERR2.
  - ERR2: dsHREADY=1, dsHRESP=ERROR. Go to ERR1 if another unmapped NONSEQ/SEQ is being accepted (HREADY=1), otherwise go to IDLE.
- IDLE or BUSY to an unmapped region: OKAY, zero wait states.

## Timing
- Address path and sHWDATA: zero latency, combinational from inputs and registers.
- Data-phase registers lag the address phase by exactly one accepted transfer (one HREADY=1 edge).
- Error response: ERR1 in the cycle after acceptance, ERR2 in the cycle after that. Exactly 2 cycles, first with wait.
- Reset values: HMASTER_dp=0, HSEL_dp=0, FSM=IDLE (dsHREADY=1, dsHRESP=00). The combinational outputs follow inputs during reset.
- Reset mid-error (in ERR1 or ERR2) returns to IDLE on the next edge, with no residual ERROR.
- HMASTER changing while HREADY=0 affects only the address outputs. The data phase holds.

## Configuration
- DEFAULT_SLAVE_EN defined: the FSM above is compiled in.
- DEFAULT_SLAVE_EN undefined: no FSM; dsHREADY tied 1 and dsHRESP tied OKAY. Unmapped accesses complete silently. Ports are unchanged in both builds.

## Structure
- Shared package ahb_pkg: HTRANS/HRESP encodings (IDLE, BUSY, NONSEQ, SEQ, OKAY, ERROR), NUM_MASTERS=5, default-slave state enum.
- One sub-module: ahb_default_slave (the FSM). Instantiated under DEFAULT_SLAVE_EN.

## Test plan
- Reset, then HMASTER=2 with HADDR2=0x3000_0010 and HTRANS2=NONSEQ, HREADY=1 -> sHADDR=0x3000_0010, HSEL=01000. Next cycle: HSEL_dp=01000, HMASTER_dp=2, sHWDATA=HWDATA2.
- HREADY=0 for 3 cycles while HMASTER switches 2->4 -> HMASTER_dp stays 2 and sHWDATA stays HWDATA2. It updates to 4 on the first HREADY=1 edge.
- HADDR=0x7000_0000 NONSEQ accepted (DEFAULT_SLAVE_EN) -> HSEL=0. Then dsHREADY=0/dsHRESP=01, then dsHREADY=1/dsHRESP=01, then OKAY.
- Unmapped IDLE transfer -> dsHREADY=1, dsHRESP=00; FSM stays IDLE.
- RESET asserted in ERR1 -> next cycle IDLE, HSEL_dp=0, HMASTER_dp=0.
- Build without DEFAULT_SLAVE_EN, unmapped NONSEQ -> dsHREADY=1, dsHRESP=00 throughout.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: encodings and types shared by the AHB interconnect blocks.
//   HTRANS codes: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ
//   HRESP codes:  HRESP_OKAY, HRESP_ERROR
//   NUM_MASTERS:  number of bus masters feeding the interconnect
//   ds_state_e:   default-slave FSM states
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int unsigned NUM_MASTERS = 5;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// AHB ERROR response (first cycle with a wait state, second completing).
// Ports:
//   i_clk       bus clock
//   i_reset     synchronous active-high reset
//   i_hready    global transfer-done; a transfer is accepted when high
//   i_unmapped  address phase is an active transfer to no decoded slave
//   o_hready    default-slave ready
//   o_hresp     default-slave response
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hready,
  input  logic       i_unmapped,
  output logic       o_hready,
  output logic [1:0] o_hresp
);

  ds_state_e r_state;
  ds_state_e w_state_nxt;
  logic      w_accept;

  assign w_accept = i_hready && i_unmapped;

  always_comb begin
    w_state_nxt = DS_IDLE;
    case (r_state)
      DS_IDLE: w_state_nxt = w_accept ? DS_ERR1 : DS_IDLE;
      DS_ERR1: w_state_nxt = DS_ERR2;
      // A back-to-back unmapped transfer restarts the error sequence.
      DS_ERR2: w_state_nxt = w_accept ? DS_ERR1 : DS_IDLE;
      default: w_state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= DS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign o_hready = (r_state != DS_ERR1);
  assign o_hresp  = (r_state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/wr_mux.sv
// wr_mux: master-to-slave half of the AHB interconnect.
// Muxes address/control from the granted master (HMASTER) and write data from
// the data-phase master onto the shared slave bus, decodes HADDR into a one-hot
// slave select, and registers the data-phase select/master for response
// steering.
// Optional feature: define DEFAULT_SLAVE_EN to include the internal default
// slave (ERROR response for unmapped accesses); otherwise dsHREADY=1 and
// dsHRESP=OKAY.
// Ports:
//   CLK, RESET                     clock, synchronous active-high reset
//   HMASTER, HREADY                granted master, global transfer-done
//   HADDRn/HTRANSn/HWRITEn/HSIZEn  per-master address/control (n = 0..4)
//   HWDATAn                        per-master write data
//   sHADDR/sHTRANS/sHWRITE/sHSIZE  muxed address/control to slaves
//   sHWDATA                        muxed write data to slaves
//   HSEL, HSEL_dp                  address-phase / data-phase slave select
//   HMASTER_dp                     data-phase master
//   dsHREADY, dsHRESP              default-slave ready/response
module wr_mux
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SLV = 5,
  parameter int unsigned DEC_LSB = 28
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [3:0]         HMASTER,
  input  logic               HREADY,
  input  logic [31:0]        HADDR0,
  input  logic [31:0]        HADDR1,
  input  logic [31:0]        HADDR2,
  input  logic [31:0]        HADDR3,
  input  logic [31:0]        HADDR4,
  input  logic [1:0]         HTRANS0,
  input  logic [1:0]         HTRANS1,
  input  logic [1:0]         HTRANS2,
  input  logic [1:0]         HTRANS3,
  input  logic [1:0]         HTRANS4,
  input  logic               HWRITE0,
  input  logic               HWRITE1,
  input  logic               HWRITE2,
  input  logic               HWRITE3,
  input  logic               HWRITE4,
  input  logic [2:0]         HSIZE0,
  input  logic [2:0]         HSIZE1,
  input  logic [2:0]         HSIZE2,
  input  logic [2:0]         HSIZE3,
  input  logic [2:0]         HSIZE4,
  input  logic [31:0]        HWDATA0,
  input  logic [31:0]        HWDATA1,
  input  logic [31:0]        HWDATA2,
  input  logic [31:0]        HWDATA3,
  input  logic [31:0]        HWDATA4,
  output logic [31:0]        sHADDR,
  output logic [1:0]         sHTRANS,
  output logic               sHWRITE,
  output logic [2:0]         sHSIZE,
  output logic [31:0]        sHWDATA,
  output logic [NUM_SLV-1:0] HSEL,
  output logic [NUM_SLV-1:0] HSEL_dp,
  output logic [3:0]         HMASTER_dp,
  output logic               dsHREADY,
  output logic [1:0]         dsHRESP
);

  logic [31:0]        w_haddr  [NUM_MASTERS];
  logic [1:0]         w_htrans [NUM_MASTERS];
  logic               w_hwrite [NUM_MASTERS];
  logic [2:0]         w_hsize  [NUM_MASTERS];
  logic [31:0]        w_hwdata [NUM_MASTERS];
  logic [3:0]         w_region;
  logic [3:0]         r_hmaster_dp;
  logic [NUM_SLV-1:0] r_hsel_dp;

  assign w_haddr  = '{HADDR0, HADDR1, HADDR2, HADDR3, HADDR4};
  assign w_htrans = '{HTRANS0, HTRANS1, HTRANS2, HTRANS3, HTRANS4};
  assign w_hwrite = '{HWRITE0, HWRITE1, HWRITE2, HWRITE3, HWRITE4};
  assign w_hsize  = '{HSIZE0, HSIZE1, HSIZE2, HSIZE3, HSIZE4};
  assign w_hwdata = '{HWDATA0, HWDATA1, HWDATA2, HWDATA3, HWDATA4};

  // Address/control mux; an illegal master index presents an IDLE transfer.
  always_comb begin
    sHADDR  = '0;
    sHTRANS = HTRANS_IDLE;
    sHWRITE = 1'b0;
    sHSIZE  = '0;
    if (HMASTER < 4'(NUM_MASTERS)) begin
      sHADDR  = w_haddr[HMASTER[2:0]];
      sHTRANS = w_htrans[HMASTER[2:0]];
      sHWRITE = w_hwrite[HMASTER[2:0]];
      sHSIZE  = w_hsize[HMASTER[2:0]];
    end
  end

  // Region decode; regions at or above NUM_SLV leave HSEL all-zero.
  assign w_region = sHADDR[DEC_LSB+3:DEC_LSB];

  always_comb begin
    HSEL = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (w_region == 4'(k)) HSEL[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hmaster_dp <= '0;
      r_hsel_dp    <= '0;
    end else if (HREADY) begin
      r_hmaster_dp <= HMASTER;
      r_hsel_dp    <= HSEL;
    end
  end

  assign HMASTER_dp = r_hmaster_dp;
  assign HSEL_dp    = r_hsel_dp;

  always_comb begin
    sHWDATA = '0;
    if (r_hmaster_dp < 4'(NUM_MASTERS)) sHWDATA = w_hwdata[r_hmaster_dp[2:0]];
  end

`ifdef DEFAULT_SLAVE_EN
  logic w_unmapped;

  assign w_unmapped = (HSEL == '0) && ((sHTRANS == HTRANS_NONSEQ) || (sHTRANS == HTRANS_SEQ));

  ahb_default_slave u_default_slave (
    .i_clk      (CLK),
    .i_reset    (RESET),
    .i_hready   (HREADY),
    .i_unmapped (w_unmapped),
    .o_hready   (dsHREADY),
    .o_hresp    (dsHRESP)
  );
`else
  assign dsHREADY = 1'b1;
  assign dsHRESP  = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_wr_mux.sv
// tb_wr_mux: directed scoreboard bench for wr_mux. Stimulus drives one cycle
// of inputs just after each rising edge and queues the hand-computed outputs
// for that cycle; the monitor compares on the falling edge.
module tb_wr_mux;

`ifdef DEFAULT_SLAVE_EN
  localparam bit DsEn = 1'b1;
`else
  localparam bit DsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  hmaster;
  logic        hready;
  logic [31:0] haddr  [5];
  logic [1:0]  htrans [5];
  logic        hwrite [5];
  logic [2:0]  hsize  [5];
  logic [31:0] hwdata [5];
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [31:0] s_hwdata;
  logic [4:0]  hsel;
  logic [4:0]  hsel_dp;
  logic [3:0]  hmaster_dp;
  logic        ds_hready;
  logic [1:0]  ds_hresp;

  always #5 clk = ~clk;

  wr_mux #(.NUM_SLV(5), .DEC_LSB(28)) dut (
    .CLK(clk), .RESET(reset), .HMASTER(hmaster), .HREADY(hready),
    .HADDR0(haddr[0]), .HADDR1(haddr[1]), .HADDR2(haddr[2]), .HADDR3(haddr[3]),
    .HADDR4(haddr[4]),
    .HTRANS0(htrans[0]), .HTRANS1(htrans[1]), .HTRANS2(htrans[2]), .HTRANS3(htrans[3]),
    .HTRANS4(htrans[4]),
    .HWRITE0(hwrite[0]), .HWRITE1(hwrite[1]), .HWRITE2(hwrite[2]), .HWRITE3(hwrite[3]),
    .HWRITE4(hwrite[4]),
    .HSIZE0(hsize[0]), .HSIZE1(hsize[1]), .HSIZE2(hsize[2]), .HSIZE3(hsize[3]),
    .HSIZE4(hsize[4]),
    .HWDATA0(hwdata[0]), .HWDATA1(hwdata[1]), .HWDATA2(hwdata[2]), .HWDATA3(hwdata[3]),
    .HWDATA4(hwdata[4]),
    .sHADDR(s_haddr), .sHTRANS(s_htrans), .sHWRITE(s_hwrite), .sHSIZE(s_hsize),
    .sHWDATA(s_hwdata), .HSEL(hsel), .HSEL_dp(hsel_dp), .HMASTER_dp(hmaster_dp),
    .dsHREADY(ds_hready), .dsHRESP(ds_hresp)
  );

  typedef struct {
    string       name;
    bit          c_addr;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    bit          c_hsel;
    logic [4:0]  hsel;
    bit          c_dp;
    logic [4:0]  hsel_dp;
    logic [3:0]  hm_dp;
    logic [31:0] wdata;
    bit          c_ds;
    logic        ds_rdy;
    logic [1:0]  ds_resp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // ds_rdy/ds_resp are given for the default-slave build; without it the
  // default slave always reads ready/OKAY.
  task automatic push(input string name,
                      input bit c_addr, input logic [31:0] a, input logic [1:0] t,
                      input logic w, input logic [2:0] s,
                      input bit c_hsel, input logic [4:0] hs,
                      input bit c_dp, input logic [4:0] hsdp, input logic [3:0] hmdp,
                      input logic [31:0] wd,
                      input bit c_ds, input logic r, input logic [1:0] rp);
    exp_t e;
    e.name = name; e.c_addr = c_addr; e.haddr = a; e.htrans = t; e.hwrite = w;
    e.hsize = s; e.c_hsel = c_hsel; e.hsel = hs; e.c_dp = c_dp; e.hsel_dp = hsdp;
    e.hm_dp = hmdp; e.wdata = wd; e.c_ds = c_ds;
    e.ds_rdy  = DsEn ? r : 1'b1;
    e.ds_resp = DsEn ? rp : 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h exp=%h", name, field, act, req);
    end
  endtask

  // Monitor: one queued expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.c_addr) begin
        cmp(e.name, "sHADDR", s_haddr, e.haddr);
        cmp(e.name, "sHTRANS", 32'(s_htrans), 32'(e.htrans));
        cmp(e.name, "sHWRITE", 32'(s_hwrite), 32'(e.hwrite));
        cmp(e.name, "sHSIZE", 32'(s_hsize), 32'(e.hsize));
      end
      if (e.c_hsel) cmp(e.name, "HSEL", 32'(hsel), 32'(e.hsel));
      if (e.c_dp) begin
        cmp(e.name, "HSEL_dp", 32'(hsel_dp), 32'(e.hsel_dp));
        cmp(e.name, "HMASTER_dp", 32'(hmaster_dp), 32'(e.hm_dp));
        cmp(e.name, "sHWDATA", s_hwdata, e.wdata);
      end
      if (e.c_ds) begin
        cmp(e.name, "dsHREADY", 32'(ds_hready), 32'(e.ds_rdy));
        cmp(e.name, "dsHRESP", 32'(ds_hresp), 32'(e.ds_resp));
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hready = 1'b1; hmaster = 4'd0;
    for (int m = 0; m < 5; m++) begin
      haddr[m] = '0; htrans[m] = 2'b00; hwrite[m] = 1'b0; hsize[m] = '0;
      hwdata[m] = 32'hD000_0000 | 32'(m);
    end
    repeat (2) next_cyc();
    // Reset state; combinational outputs follow master 0 (address 0 -> slave 0).
    push("reset", 1, 32'h0, 2'b00, 0, 3'd0, 1, 5'b00001, 1, 5'b0, 4'd0, 32'hD000_0000,
         1, 1, 2'b00);
    next_cyc();

    // Master 2 NONSEQ write to region 3.
    reset = 1'b0; hmaster = 4'd2;
    haddr[2] = 32'h3000_0010; htrans[2] = 2'b10; hwrite[2] = 1'b1; hsize[2] = 3'd2;
    push("m2_addr", 1, 32'h3000_0010, 2'b10, 1, 3'd2, 1, 5'b01000, 1, 5'b0, 4'd0,
         32'hD000_0000, 1, 1, 2'b00);
    next_cyc();

    // Stall while the grant moves to master 4.
    hready = 1'b0; hmaster = 4'd4;
    haddr[4] = 32'h1000_0040; htrans[4] = 2'b10; hwrite[4] = 1'b0; hsize[4] = 3'd0;
    push("m2_data", 1, 32'h1000_0040, 2'b10, 0, 3'd0, 1, 5'b00010, 1, 5'b01000, 4'd2,
         32'hD000_0002, 1, 1, 2'b00);
    next_cyc();
    push("stall2", 0, 0, 0, 0, 0, 1, 5'b00010, 1, 5'b01000, 4'd2, 32'hD000_0002, 0, 0, 0);
    next_cyc();
    push("stall3", 0, 0, 0, 0, 0, 0, 0, 1, 5'b01000, 4'd2, 32'hD000_0002, 0, 0, 0);
    next_cyc();
    hready = 1'b1;
    push("release", 0, 0, 0, 0, 0, 0, 0, 1, 5'b01000, 4'd2, 32'hD000_0002, 0, 0, 0);
    next_cyc();
    htrans[4] = 2'b00;
    push("m4_data", 0, 0, 0, 0, 0, 0, 0, 1, 5'b00010, 4'd4, 32'hD000_0004, 1, 1, 2'b00);
    next_cyc();

    // Unmapped NONSEQ from master 1 -> two-cycle ERROR.
    hmaster = 4'd1; haddr[1] = 32'h7000_0000; htrans[1] = 2'b10;
    push("unm_addr", 1, 32'h7000_0000, 2'b10, 0, 3'd0, 1, 5'b0, 1, 5'b00010, 4'd4,
         32'hD000_0004, 1, 1, 2'b00);
    next_cyc();
    hready = 1'b0; htrans[1] = 2'b00;
    push("err1", 0, 0, 0, 0, 0, 1, 5'b0, 1, 5'b0, 4'd1, 32'hD000_0001, 1, 0, 2'b01);
    next_cyc();
    hready = 1'b1;
    push("err2", 0, 0, 0, 0, 0, 0, 0, 1, 5'b0, 4'd1, 32'hD000_0001, 1, 1, 2'b01);
    next_cyc();
    push("err_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    next_cyc();

    // Unmapped IDLE and BUSY complete OKAY with no wait.
    push("unm_idle", 1, 32'h7000_0000, 2'b00, 0, 3'd0, 1, 5'b0, 0, 0, 0, 0, 1, 1, 2'b00);
    next_cyc();
    htrans[1] = 2'b01;
    push("unm_busy", 0, 0, 0, 0, 0, 1, 5'b0, 0, 0, 0, 0, 1, 1, 2'b00);
    next_cyc();

    // Back-to-back unmapped NONSEQ, then reset while in ERR1.
    htrans[1] = 2'b10;
    push("b2b_addr", 0, 0, 0, 0, 0, 0, 0, 1, 5'b0, 4'd1, 32'hD000_0001, 1, 1, 2'b00);
    next_cyc();
    hready = 1'b0;
    push("b2b_err1a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01);
    next_cyc();
    hready = 1'b1;
    push("b2b_err2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01);
    next_cyc();
    reset = 1'b1; hready = 1'b0;
    push("b2b_err1b", 0, 0, 0, 0, 0, 0, 0, 1, 5'b0, 4'd1, 32'hD000_0001, 1, 0, 2'b01);
    next_cyc();
    reset = 1'b0; hready = 1'b1; htrans[1] = 2'b00;
    push("rst_err", 0, 0, 0, 0, 0, 1, 5'b0, 1, 5'b0, 4'd0, 32'hD000_0000, 1, 1, 2'b00);
    next_cyc();

    // Illegal master index and region boundaries.
    hmaster = 4'd7;
    push("hm7_addr", 1, 32'h0, 2'b00, 0, 3'd0, 1, 5'b00001, 1, 5'b0, 4'd1, 32'hD000_0001,
         1, 1, 2'b00);
    next_cyc();
    hmaster = 4'd0; haddr[0] = 32'h4000_0000; htrans[0] = 2'b10; hwrite[0] = 1'b1;
    hsize[0] = 3'd1;
    push("reg4", 1, 32'h4000_0000, 2'b10, 1, 3'd1, 1, 5'b10000, 1, 5'b00001, 4'd7, 32'h0,
         1, 1, 2'b00);
    next_cyc();
    haddr[0] = 32'h5000_0000;
    push("reg5", 0, 0, 0, 0, 0, 1, 5'b0, 1, 5'b10000, 4'd0, 32'hD000_0000, 1, 1, 2'b00);
    next_cyc();
    hready = 1'b0; htrans[0] = 2'b00;
    push("reg5_err1", 0, 0, 0, 0, 0, 0, 0, 1, 5'b0, 4'd0, 32'hD000_0000, 1, 0, 2'b01);
    next_cyc();
    hready = 1'b1;
    push("reg5_err2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01);
    next_cyc();
    push("reg5_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
